// File: rtl/eth_payload_ser_if.sv
// Handshake bundle between the packetizer/FIFO, eth_payload_ser and the MAC framing stage.
// The master side is the environment; the slave side is the serializer.
interface eth_payload_ser_if;
  logic        eth_tx_start;
  logic [15:0] eth_tx_data_num;
  logic [31:0] eth_tx_data;
  logic        mac_ready;
  logic        eth_tx_req;
  logic        eth_tx_done;
  logic [7:0]  mac_data;
  logic        mac_valid;
  logic        mac_last;
  logic        busy;
  logic [15:0] payload_csum;

  modport master (
    output eth_tx_start, eth_tx_data_num, eth_tx_data, mac_ready,
    input  eth_tx_req, eth_tx_done, mac_data, mac_valid, mac_last, busy, payload_csum
  );

  modport slave (
    input  eth_tx_start, eth_tx_data_num, eth_tx_data, mac_ready,
    output eth_tx_req, eth_tx_done, mac_data, mac_valid, mac_last, busy, payload_csum
  );
endinterface

// File: rtl/eth_payload_ser.sv
// Serializes 32-bit FIFO words big-endian into a byte stream for the MAC/UDP stage.
// Optional payload checksum enabled by defining ETH_PAYLOAD_SER_CSUM_EN.
module eth_payload_ser (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  eth_payload_ser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bytes_left_q, bytes_left_d;
  logic [13:0] words_left_q, words_left_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [15:0] num_m1;
  logic [7:0]  cur_byte;
  logic        hs;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      bytes_left_q <= 16'd0;
      words_left_q <= 14'd0;
      byte_idx_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    word_q <= word_d;
  end

  assign hs = (state_q == S_SEND) && bus.mac_ready;

  always_comb begin
    cur_byte = 8'h00;
    if (state_q == S_SEND) begin
      unique case (byte_idx_q)
        2'd0: cur_byte = word_q[31:24];
        2'd1: cur_byte = word_q[23:16];
        2'd2: cur_byte = word_q[15:8];
        2'd3: cur_byte = word_q[7:0];
      endcase
    end
  end

  // words_left counts reads still owed after the one in flight, so the
  // 65535-byte case (16384 reads) fits in 14 bits without wrapping.
  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    num_m1       = bus.eth_tx_data_num - 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.eth_tx_start) begin
          if (bus.eth_tx_data_num != 16'd0) begin
            state_d      = S_REQ;
            bytes_left_d = bus.eth_tx_data_num;
            words_left_d = num_m1[15:2];
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: state_d = S_LOAD;
      S_LOAD: begin
        word_d     = bus.eth_tx_data;
        byte_idx_d = 2'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          bytes_left_d = bytes_left_q - 16'd1;
          if (bytes_left_q == 16'd1) begin
            state_d = S_DONE;
          end else if (byte_idx_q == 2'd3) begin
            if (words_left_q != 14'd0) begin
              state_d      = S_REQ;
              words_left_d = words_left_q - 14'd1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.eth_tx_req  = (state_q == S_REQ);
  assign bus.eth_tx_done = (state_q == S_DONE);
  assign bus.mac_valid   = (state_q == S_SEND);
  assign bus.mac_last    = (state_q == S_SEND) && (bytes_left_q == 16'd1);
  assign bus.mac_data    = cur_byte;
  assign bus.busy        = (state_q != S_IDLE);

`ifdef ETH_PAYLOAD_SER_CSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic        phase_q, phase_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] pair;
  logic [15:0] sum;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) csum_q <= 16'h0000;
    else            csum_q <= csum_d;
  end

  always_ff @(posedge sys_clk) begin
    acc_q   <= acc_d;
    hi_q    <= hi_d;
    phase_q <= phase_d;
  end

  // Even-position bytes wait in hi_q; a trailing odd byte is padded with 8'h00.
  always_comb begin
    acc_d   = acc_q;
    hi_d    = hi_q;
    phase_d = phase_q;
    csum_d  = csum_q;
    pair    = phase_q ? {hi_q, cur_byte} : {cur_byte, 8'h00};
    sum     = ones_add(acc_q, pair);
    if ((state_q == S_IDLE) && bus.eth_tx_start) begin
      acc_d   = 16'h0000;
      phase_d = 1'b0;
      if (bus.eth_tx_data_num == 16'd0) csum_d = 16'h0000;
    end
    if (hs) begin
      phase_d = ~phase_q;
      if (phase_q) acc_d = sum;
      else         hi_d  = cur_byte;
      if (bytes_left_q == 16'd1) csum_d = sum;
    end
  end

  assign bus.payload_csum = csum_q;
`else
  assign bus.payload_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_payload_ser.sv
// Directed self-checking bench for eth_payload_ser with a small FIFO model and byte monitor.
`timescale 1ns/1ps
module tb_eth_payload_ser;

`ifdef ETH_PAYLOAD_SER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  eth_payload_ser_if ifc();

  eth_payload_ser dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifc.slave)
  );

  always #20 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] fifo [0:319];
  int          rd_ptr;
  int          cyc = 0;
  int          t0;
  logic [7:0]  got[$];
  int          req_cnt, last_cnt, busy_cnt, done_cyc;
  logic [7:0]  last_byte;
  logic [15:0] done_csum;
  int          stall_at = -1;
  int          stall_len = 0;
  int          stall_cnt;
  logic [8:0]  held;
  bit          hold_bad, last_bad;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Monitor and FIFO model, evaluated mid-cycle.
  initial begin
    ifc.mac_ready   = 1'b1;
    ifc.eth_tx_data = 32'h0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (ifc.mac_valid && got.size() == stall_at && stall_cnt < stall_len) begin
          ifc.mac_ready = 1'b0;
          if (stall_cnt == 0) held = {ifc.mac_last, ifc.mac_data};
          else if (held !== {ifc.mac_last, ifc.mac_data}) hold_bad = 1'b1;
          stall_cnt++;
        end else begin
          if (stall_cnt != 0 && got.size() == stall_at && ifc.mac_valid &&
              held !== {ifc.mac_last, ifc.mac_data}) hold_bad = 1'b1;
          ifc.mac_ready = 1'b1;
        end
        if (ifc.mac_valid && ifc.mac_ready) begin
          got.push_back(ifc.mac_data);
          if (ifc.mac_last) begin
            last_cnt++;
            last_byte = ifc.mac_data;
          end
        end
        if (ifc.mac_last && !ifc.mac_valid) last_bad = 1'b1;
        if (ifc.eth_tx_req) begin
          req_cnt++;
          if (rd_ptr < 320) ifc.eth_tx_data = fifo[rd_ptr];
          rd_ptr++;
        end
        if (ifc.busy) busy_cnt++;
        if (ifc.eth_tx_done && done_cyc < 0) begin
          done_cyc  = cyc;
          done_csum = ifc.payload_csum;
        end
      end
    end
  end

  task automatic clear_mon();
    got.delete();
    req_cnt   = 0;
    last_cnt  = 0;
    busy_cnt  = 0;
    done_cyc  = -1;
    rd_ptr    = 0;
    stall_cnt = 0;
    hold_bad  = 1'b0;
    last_bad  = 1'b0;
    last_byte = 8'h00;
  endtask

  task automatic start_pkt(input int num);
    @(posedge sys_clk);
    #1;
    ifc.eth_tx_start    = 1'b1;
    ifc.eth_tx_data_num = num[15:0];
    t0 = cyc;
    @(posedge sys_clk);
    #1;
    ifc.eth_tx_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_cyc < 0; i++) @(posedge sys_clk);
    if (done_cyc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_pkt(input string tag, input int num, input int exp_req, input int exp_lat,
                           input bit do_csum, input logic [15:0] exp_csum);
    logic [31:0] w;
    logic [7:0]  e;
    chk({tag, "_nbytes"}, got.size(), num);
    for (int i = 0; i < got.size() && i < num; i++) begin
      w = fifo[i / 4];
      e = w[8 * (3 - (i % 4)) +: 8];
      chk($sformatf("%s_byte%0d", tag, i), got[i], e);
    end
    chk({tag, "_last_cnt"}, last_cnt, (num > 0) ? 1 : 0);
    if (num > 0) begin
      w = fifo[(num - 1) / 4];
      e = w[8 * (3 - ((num - 1) % 4)) +: 8];
      chk({tag, "_last_byte"}, last_byte, e);
    end
    chk({tag, "_reqs"}, req_cnt, exp_req);
    chk({tag, "_done_lat"}, done_cyc - t0, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    chk({tag, "_last_wo_valid"}, last_bad, 1'b0);
    chk({tag, "_busy_after"}, ifc.busy, 1'b0);
    if (do_csum) chk({tag, "_csum"}, done_csum, exp_csum);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   ifc.eth_tx_req,   1'b0);
    chk({tag, "_done"},  ifc.eth_tx_done,  1'b0);
    chk({tag, "_data"},  ifc.mac_data,     8'h00);
    chk({tag, "_valid"}, ifc.mac_valid,    1'b0);
    chk({tag, "_last"},  ifc.mac_last,     1'b0);
    chk({tag, "_busy"},  ifc.busy,         1'b0);
    chk({tag, "_csum"},  ifc.payload_csum, 16'h0000);
  endtask

  task automatic run_eight(input string tag);
    clear_mon();
    fifo[0] = 32'h11223344;
    fifo[1] = 32'h55667788;
    start_pkt(8);
    wait_done(tag);
    check_pkt(tag, 8, 2, 13, 1'b1, CSUM_ON ? 16'h1155 : 16'h0000);
  endtask

  initial begin
    bit seen;
    ifc.eth_tx_start    = 1'b0;
    ifc.eth_tx_data_num = 16'd0;
    #30;
    check_reset_vals("por");
    repeat (2) @(posedge sys_clk);
    #5 sys_rst_n = 1'b1;

    run_eight("n8");

    clear_mon();
    fifo[0] = 32'hAABBCCDD;
    fifo[1] = 32'hEEFF0011;
    start_pkt(6);
    wait_done("n6");
    check_pkt("n6", 6, 2, 11, 1'b1, CSUM_ON ? 16'h6699 : 16'h0000);

    clear_mon();
    fifo[0]   = 32'h01020304;
    stall_at  = 2;
    stall_len = 5;
    start_pkt(4);
    repeat (2) @(posedge sys_clk);
    #1;
    ifc.eth_tx_start    = 1'b1;
    ifc.eth_tx_data_num = 16'd4;
    @(posedge sys_clk);
    #1;
    ifc.eth_tx_start = 1'b0;
    wait_done("stall");
    check_pkt("stall", 4, 1, 12, 1'b1, CSUM_ON ? 16'h0406 : 16'h0000);
    chk("stall_hold", hold_bad, 1'b0);
    chk("stall_len", stall_cnt, 5);
    stall_at  = -1;
    stall_len = 0;

    clear_mon();
    start_pkt(0);
    wait_done("n0");
    check_pkt("n0", 0, 0, 1, 1'b1, 16'h0000);

    clear_mon();
    fifo[0] = 32'hFFFF0001;
    start_pkt(4);
    wait_done("ffff");
    check_pkt("ffff", 4, 1, 7, 1'b1, CSUM_ON ? 16'h0001 : 16'h0000);

    clear_mon();
    fifo[0] = 32'h00010200;
    start_pkt(3);
    wait_done("n3");
    check_pkt("n3", 3, 1, 6, 1'b1, CSUM_ON ? 16'h0201 : 16'h0000);

    clear_mon();
    for (int i = 0; i < 320; i++) fifo[i] = {i[7:0], 8'hA5, i[15:8], 8'h3C};
    start_pkt(1280);
    wait_done("n1280");
    check_pkt("n1280", 1280, 320, 1921, 1'b0, 16'h0000);

    clear_mon();
    start_pkt(1280);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge sys_clk);
      #5;
      if (got.size() >= 10 && ifc.mac_valid) seen = 1'b1;
    end
    chk("rst_reached_send", seen, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(posedge sys_clk);
    #5 sys_rst_n = 1'b1;

    run_eight("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
